// File: rtl/nas2_vid_seq_if.sv
// NASCOM 2 video sequencer bus: PROM, video outputs and CPU VRAM handshake.
// master = sequencer side, slave = board/environment side.
interface nas2_vid_seq_if;
    logic       dot_en;
    logic       prom_ce_n;
    logic [4:0] prom_a;
    logic [1:0] prom_d;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic [9:0] vram_addr;
    logic [3:0] ra;
    logic       load_sr;
    logic       frame_start;
    logic       cpu_req;
    logic       cpu_gnt;
    logic       cpu_wait;

    modport master (
        input  dot_en, prom_d, cpu_req,
        output prom_ce_n, prom_a, hsync_n, vsync_n, blank_n,
        output vram_addr, ra, load_sr, frame_start,
        output cpu_gnt, cpu_wait
    );

    modport slave (
        output dot_en, prom_d, cpu_req,
        input  prom_ce_n, prom_a, hsync_n, vsync_n, blank_n,
        input  vram_addr, ra, load_sr, frame_start,
        input  cpu_gnt, cpu_wait
    );
endinterface

// File: rtl/nas2_vid_seq.sv
// NASCOM 2 video timing sequencer and VRAM arbiter.
// NAS_VID_NOSNOW_EN: CPU access held off (WAIT) while the beam is visible.
module nas2_vid_seq #(
    parameter int DOT_DIV      = 8,
    parameter int V_LINES      = 312,
    parameter int ROW_LINES    = 16,
    parameter int V_ROWS       = 16,
    parameter int V_SYNC_START = 280,
    parameter int V_SYNC_LEN   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    nas2_vid_seq_if.master bus
);
    localparam int DW  = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
    localparam int LW  = $clog2(V_LINES);
    localparam int VIS = V_ROWS * ROW_LINES;

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_GNT} cst_e;

    logic [DW-1:0] dot_q, dot_d;
    logic [5:0]    hcnt_q, hcnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [3:0]    ra_q, ra_d;
    logic [3:0]    row_q, row_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic          bl_q, bl_d, fs_q, fs_d;
    logic          ce_n_q;
    logic          cell_end, line_end, frame_end;
    cst_e          cst_q;
    logic          gnt_q, wait_q;

    always_comb begin
        cell_end  = bus.dot_en && (dot_q == DW'(DOT_DIV - 1));
        line_end  = cell_end && (hcnt_q == 6'd63);
        frame_end = line_end && (line_q == LW'(V_LINES - 1));
        dot_d  = dot_q;
        hcnt_d = hcnt_q;
        line_d = line_q;
        ra_d   = ra_q;
        row_d  = row_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        bl_d   = bl_q;
        fs_d   = frame_end;
        if (bus.dot_en)
            dot_d = cell_end ? '0 : dot_q + 1'b1;
        // PROM data belongs to the cell just finished: one cell of latency
        if (cell_end) begin
            hcnt_d = hcnt_q + 1'b1;
            hs_d   = bus.prom_d[0];
            bl_d   = bus.prom_d[1] && (int'(line_q) < VIS);
        end
        if (line_end) begin
            line_d = frame_end ? '0 : line_q + 1'b1;
            if (frame_end) begin
                ra_d  = '0;
                row_d = '0;
            end else if (ra_q == 4'(ROW_LINES - 1)) begin
                ra_d  = '0;
                row_d = row_q + 1'b1;
            end else begin
                ra_d  = ra_q + 1'b1;
            end
            vs_d = !((int'(line_d) >= V_SYNC_START) &&
                     (int'(line_d) < V_SYNC_START + V_SYNC_LEN));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dot_q  <= '0;
            hcnt_q <= '0;
            line_q <= '0;
            ra_q   <= '0;
            row_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            bl_q   <= 1'b0;
            fs_q   <= 1'b0;
            ce_n_q <= 1'b1;
        end else begin
            dot_q  <= dot_d;
            hcnt_q <= hcnt_d;
            line_q <= line_d;
            ra_q   <= ra_d;
            row_q  <= row_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            bl_q   <= bl_d;
            fs_q   <= fs_d;
            ce_n_q <= 1'b0;
        end
    end

    // ce_n_q still high masks a request seen on the reset-release clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cst_q  <= C_IDLE;
            gnt_q  <= 1'b0;
            wait_q <= 1'b0;
        end else begin
            unique case (cst_q)
                C_IDLE: begin
                    if (bus.cpu_req && !ce_n_q) begin
`ifdef NAS_VID_NOSNOW_EN
                        if (bl_q) begin
                            cst_q  <= C_WAIT;
                            wait_q <= 1'b1;
                        end else begin
                            cst_q <= C_GNT;
                            gnt_q <= 1'b1;
                        end
`else
                        cst_q <= C_GNT;
                        gnt_q <= 1'b1;
`endif
                    end
                end
                C_WAIT: begin
                    if (!bus.cpu_req) begin
                        cst_q  <= C_IDLE;
                        wait_q <= 1'b0;
                    end else if (!bl_d) begin
                        cst_q  <= C_GNT;
                        gnt_q  <= 1'b1;
                        wait_q <= 1'b0;
                    end
                end
                C_GNT: begin
                    if (!bus.cpu_req) begin
                        cst_q <= C_IDLE;
                        gnt_q <= 1'b0;
                    end
                end
                default: begin
                    cst_q  <= C_IDLE;
                    gnt_q  <= 1'b0;
                    wait_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prom_ce_n   = ce_n_q;
    assign bus.prom_a      = hcnt_q[5:1];
    assign bus.hsync_n     = hs_q;
    assign bus.vsync_n     = vs_q;
    assign bus.blank_n     = bl_q;
    assign bus.vram_addr   = {row_q, hcnt_q};
    assign bus.ra          = ra_q;
    assign bus.load_sr     = cell_end && bl_q;
    assign bus.frame_start = fs_q;
    assign bus.cpu_gnt     = gnt_q;
    assign bus.cpu_wait    = wait_q;
endmodule

// File: tb/tb_nas2_vid_seq.sv
// Directed bench for nas2_vid_seq, DOT_DIV=2 so one line is 128 clks.
// k counts enabled clks since reset release: line=k/128, hcnt=(k/2)%64.
module tb_nas2_vid_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   k, fs_cnt, total, bad;

    nas2_vid_seq_if vif ();

    nas2_vid_seq #(.DOT_DIV(2)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif.master)
    );

    always #5 clk = ~clk;

    // PROM: addr 0 = blanked, addr 1 = hsync, rest visible
    always_comb begin
        if (vif.prom_a == 5'd0)      vif.prom_d = 2'b01;
        else if (vif.prom_a == 5'd1) vif.prom_d = 2'b00;
        else                         vif.prom_d = 2'b11;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
            fs_cnt = 0;
        end else if (vif.dot_en) begin
            k++;
        end
        #1;
        if (vif.frame_start) fs_cnt++;
    endtask

    task automatic goto(input int t);
        int n = 0;
        while (k < t && n < 60000) begin
            tick();
            n++;
        end
        check("goto", k, t);
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_ce"},  vif.prom_ce_n, 1);
        check({tag, "_pa"},  vif.prom_a, 0);
        check({tag, "_hs"},  vif.hsync_n, 1);
        check({tag, "_vs"},  vif.vsync_n, 1);
        check({tag, "_bl"},  vif.blank_n, 0);
        check({tag, "_va"},  vif.vram_addr, 0);
        check({tag, "_ra"},  vif.ra, 0);
        check({tag, "_ld"},  vif.load_sr, 0);
        check({tag, "_fs"},  vif.frame_start, 0);
        check({tag, "_gnt"}, vif.cpu_gnt, 0);
        check({tag, "_wt"},  vif.cpu_wait, 0);
    endtask

    initial begin
        total = 0; bad = 0; k = 0; fs_cnt = 0;
        rst_n = 1'b0;
        vif.dot_en = 1'b1;
        vif.cpu_req = 1'b0;
        repeat (3) tick();
        check_rst("rst");

        rst_n = 1'b1;
        tick();
        check("ce_on", vif.prom_ce_n, 0);
        check("pa_k1", vif.prom_a, 0);
        check("hs_k1", vif.hsync_n, 1);
        check("bl_k1", vif.blank_n, 0);
        check("vs_k1", vif.vsync_n, 1);

        goto(4);    check("pa_h2", vif.prom_a, 1);
        goto(5);    check("hs_h2", vif.hsync_n, 1);
        goto(6);    check("hs_h3", vif.hsync_n, 0);
        goto(7);    check("ld_h3", vif.load_sr, 0);
        goto(9);    check("hs_h4", vif.hsync_n, 0);
                    check("bl_h4", vif.blank_n, 0);
        goto(10);   check("hs_h5", vif.hsync_n, 1);
                    check("bl_h5", vif.blank_n, 1);
                    check("ld_h5d0", vif.load_sr, 0);
        goto(11);   check("ld_h5d1", vif.load_sr, 1);
        goto(127);  check("pa_h63", vif.prom_a, 31);
        goto(128);  check("bl_l1h0", vif.blank_n, 1);
                    check("ra_l1", vif.ra, 1);
                    check("fs_l1", vif.frame_start, 0);
        goto(130);  check("bl_l1h1", vif.blank_n, 0);
        goto(138);  check("va_l1h5", vif.vram_addr, 5);

        vif.dot_en = 1'b0;
        repeat (3) tick();
        check("frz_va", vif.vram_addr, 5);
        check("frz_ld", vif.load_sr, 0);
        vif.dot_en = 1'b1;

        goto(1320);
        vif.cpu_req = 1'b1;
        tick();
`ifdef NAS_VID_NOSNOW_EN
        check("ns_wt", vif.cpu_wait, 1);
        check("ns_gnt0", vif.cpu_gnt, 0);
        goto(1409);
        check("ns_wt2", vif.cpu_wait, 1);
        check("ns_gnt1", vif.cpu_gnt, 0);
        goto(1410);
        check("ns_bl", vif.blank_n, 0);
        check("ns_gnt", vif.cpu_gnt, 1);
        check("ns_wt0", vif.cpu_wait, 0);
`else
        check("sn_gnt", vif.cpu_gnt, 1);
        check("sn_wt", vif.cpu_wait, 0);
`endif
        vif.cpu_req = 1'b0;
        tick();
        check("rel_gnt", vif.cpu_gnt, 0);

        goto(2048); check("ra_l16", vif.ra, 0);
                    check("va_l16", vif.vram_addr, 64);
        goto(2058); check("va_l16h5", vif.vram_addr, 69);

        goto(12804);
        vif.cpu_req = 1'b1;
        tick();
        check("l100_gnt", vif.cpu_gnt, 1);
        rst_n = 1'b0;
        tick();
        check_rst("mid");
        rst_n = 1'b1;
        tick();
        check("rel_ce", vif.prom_ce_n, 0);
        check("rel_gnt0", vif.cpu_gnt, 0);
        tick();
        check("rel_gnt1", vif.cpu_gnt, 1);
        vif.cpu_req = 1'b0;
        tick();
        check("rel_gnt2", vif.cpu_gnt, 0);

        goto(32660); check("bl_l255", vif.blank_n, 1);
        goto(32661); check("ld_l255", vif.load_sr, 1);
        goto(32788); check("bl_l256", vif.blank_n, 0);
        goto(32789); check("ld_l256", vif.load_sr, 0);
        goto(35839); check("vs_l279", vif.vsync_n, 1);
        goto(35840); check("vs_l280", vif.vsync_n, 0);
        goto(36351); check("vs_l283", vif.vsync_n, 0);
        goto(36352); check("vs_l284", vif.vsync_n, 1);

        goto(38440);
        vif.cpu_req = 1'b1;
        tick();
        check("l300_gnt", vif.cpu_gnt, 1);
        check("l300_wt", vif.cpu_wait, 0);
        vif.cpu_req = 1'b0;
        tick();
        check("l300_rel", vif.cpu_gnt, 0);

        goto(39935); check("fs_pre", vif.frame_start, 0);
                     check("fs_cnt0", fs_cnt, 0);
        goto(39936); check("fs_on", vif.frame_start, 1);
                     check("fs_va", vif.vram_addr, 0);
                     check("fs_ra", vif.ra, 0);
                     check("fs_vs", vif.vsync_n, 1);
        goto(39937); check("fs_off", vif.frame_start, 0);
                     check("fs_cnt1", fs_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
